// File: rtl/stream_mux_rr_if.sv
// Handshake bundle between N producer streams, the stream mux and its single consumer.
// The mux takes the slave view; whoever drives the producers and the consumer takes the master view.
interface stream_mux_rr_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_chan;
    logic               out_ready;

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_chan
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux feeding one registered output stage.
// Arbitration is round-robin from a rotating pointer (RR=1) or follows the sel port (RR=0).
module stream_mux_rr #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int RR    = 1
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;
    logic               can_load_s;
    logic               grant_vld_s;
    logic [SEL_W-1:0]   grant_s;
    logic [N-1:0]       in_ready_s;

    // (base + k) mod N for base < N and 0 <= k < N.
    function automatic logic [SEL_W-1:0] rr_index(input logic [SEL_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return SEL_W'(sum);
    endfunction

    // Scan from base upward with wrap; the reverse loop lets the nearest hit win.
    function automatic logic [SEL_W:0] rr_pick(input logic [N-1:0] valid, input logic [SEL_W-1:0] base);
        logic [SEL_W:0] pick;
        pick = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[rr_index(base, k)]) begin
                pick = {1'b1, rr_index(base, k)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [SEL_W:0] fixed_pick(input logic [N-1:0] valid, input logic [SEL_W-1:0] s);
        logic [SEL_W:0] pick;
        pick = '0;
        for (int i = 0; i < N; i++) begin
            if ((s == SEL_W'(i)) && valid[i]) begin
                pick = {1'b1, SEL_W'(i)};
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [WIDTH-1:0] pick_data(input logic [N*WIDTH-1:0] data, input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] word;
        word = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SEL_W'(i)) begin
                word = data[i*WIDTH +: WIDTH];
            end else begin
                word = word;
            end
        end
        return word;
    endfunction

    assign can_load_s = !out_valid_q || bus.out_ready;

    // Channel arbitration; a sel value of N or above never matches a channel.
    always_comb begin
        if (RR != 0) begin
            {grant_vld_s, grant_s} = rr_pick(bus.in_valid, ptr_q);
        end else begin
            {grant_vld_s, grant_s} = fixed_pick(bus.in_valid, bus.sel);
        end
    end

    // One-hot ready toward the granted producer, held low during reset.
    always_comb begin
        in_ready_s = '0;
        for (int i = 0; i < N; i++) begin
            in_ready_s[i] = !rst && can_load_s && grant_vld_s && (grant_s == SEL_W'(i));
        end
    end

    // Output stage and pointer next state: load on grant, empty on idle, hold on backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (can_load_s) begin
            if (grant_vld_s) begin
                out_valid_d = 1'b1;
                out_data_d  = pick_data(bus.in_data, grant_s);
                out_chan_d  = grant_s;
                ptr_d       = (RR != 0) ? rr_index(grant_s, 1) : ptr_q;
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: round-robin N=4, fixed-select N=4 and round-robin N=3 instances
// checked against a cycle model plus an in-order beat scoreboard.
module tb_stream_mux_rr;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    stream_mux_rr_if #(.WIDTH(8), .N(4)) if4 ();
    stream_mux_rr_if #(.WIDTH(8), .N(4)) if0 ();
    stream_mux_rr_if #(.WIDTH(8), .N(3)) if3 ();

    stream_mux_rr #(.WIDTH(8), .N(4), .RR(1)) u_rr4 (.clk(clk), .rst(rst), .bus(if4));
    stream_mux_rr #(.WIDTH(8), .N(4), .RR(0)) u_sel4 (.clk(clk), .rst(rst), .bus(if0));
    stream_mux_rr #(.WIDTH(8), .N(3), .RR(1)) u_rr3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus per instance (0: rr4, 1: sel4, 2: rr3)
    logic [3:0]  iv [3];
    logic [7:0]  id [3][4];
    logic [1:0]  sel_v [3];
    logic        ordy [3];
    logic [3:0]  acc [3];
    // Reference model state
    int          m_ptr [3];
    logic        m_ov [3];
    logic [7:0]  m_od [3];
    int          m_oc [3];
    logic [15:0] sbq [3][$];
    int          nn [3]  = '{4, 4, 3};
    int          rrm [3] = '{1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] get_rdy(input int d);
        case (d)
            0:       return if4.in_ready;
            1:       return if0.in_ready;
            default: return {1'b0, if3.in_ready};
        endcase
    endfunction

    function automatic logic get_ov(input int d);
        case (d)
            0:       return if4.out_valid;
            1:       return if0.out_valid;
            default: return if3.out_valid;
        endcase
    endfunction

    function automatic logic [7:0] get_od(input int d);
        case (d)
            0:       return if4.out_data;
            1:       return if0.out_data;
            default: return if3.out_data;
        endcase
    endfunction

    function automatic logic [1:0] get_oc(input int d);
        case (d)
            0:       return if4.out_chan;
            1:       return if0.out_chan;
            default: return if3.out_chan;
        endcase
    endfunction

    // Grant by the arbitration rules: wrapped scan from ptr, or sel when valid and in range.
    function automatic int model_grant(input int n, input int rr, input int ptr, input logic [3:0] v, input int s);
        if (rr != 0) begin
            for (int k = 0; k < n; k++) begin
                if (v[(ptr + k) % n]) return (ptr + k) % n;
            end
        end else if (s < n && v[s]) begin
            return s;
        end
        return -1;
    endfunction

    task automatic apply();
        if4.in_valid  = iv[0];
        if4.in_data   = {id[0][3], id[0][2], id[0][1], id[0][0]};
        if4.sel       = sel_v[0];
        if4.out_ready = ordy[0];
        if0.in_valid  = iv[1];
        if0.in_data   = {id[1][3], id[1][2], id[1][1], id[1][0]};
        if0.sel       = sel_v[1];
        if0.out_ready = ordy[1];
        if3.in_valid  = iv[2][2:0];
        if3.in_data   = {id[2][2], id[2][1], id[2][0]};
        if3.sel       = sel_v[2];
        if3.out_ready = ordy[2];
    endtask

    task automatic step();
        int         g;
        bit         cl;
        logic [3:0] rdy_exp;
        logic [15:0] beat;
        apply();
        #1;
        for (int d = 0; d < 3; d++) begin
            cl      = !m_ov[d] || ordy[d];
            g       = model_grant(nn[d], rrm[d], m_ptr[d], iv[d], int'(sel_v[d]));
            rdy_exp = (cl && g >= 0) ? 4'(1 << g) : 4'b0000;
            chk($sformatf("in_ready u%0d", d), 32'(get_rdy(d)), 32'(rdy_exp));
            if (m_ov[d] && ordy[d]) begin
                if (sbq[d].size() > 0) begin
                    beat = sbq[d].pop_front();
                    chk($sformatf("sb_beat u%0d", d), {16'h0000, 8'(get_oc(d)), get_od(d)}, 32'(beat));
                end else begin
                    total++;
                    bad++;
                    $error("FAIL sb_empty u%0d observed=drain expected=no_beat", d);
                end
            end
            acc[d] = rdy_exp;
            if (cl) begin
                if (g >= 0) begin
                    m_ov[d] = 1'b1;
                    m_od[d] = id[d][g];
                    m_oc[d] = g;
                    if (rrm[d] != 0) m_ptr[d] = (g + 1) % nn[d];
                    sbq[d].push_back({8'(g), id[d][g]});
                end else begin
                    m_ov[d] = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("out_valid u%0d", d), 32'(get_ov(d)), 32'(m_ov[d]));
            chk($sformatf("out_data u%0d", d), 32'(get_od(d)), 32'(m_od[d]));
            chk($sformatf("out_chan u%0d", d), 32'(get_oc(d)), 32'(m_oc[d]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst out_valid u%0d", d), 32'(get_ov(d)), 32'd0);
            chk($sformatf("rst out_data u%0d", d), 32'(get_od(d)), 32'd0);
            chk($sformatf("rst out_chan u%0d", d), 32'(get_oc(d)), 32'd0);
            chk($sformatf("rst in_ready u%0d", d), 32'(get_rdy(d)), 32'd0);
            m_ptr[d] = 0;
            m_ov[d]  = 1'b0;
            m_od[d]  = 8'h00;
            m_oc[d]  = 0;
            acc[d]   = 4'b0000;
            sbq[d].delete();
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic rand_inputs();
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < nn[d]; c++) begin
                if (!(iv[d][c] && !acc[d][c])) begin
                    iv[d][c] = 1'($urandom_range(0, 1));
                    id[d][c] = 8'($urandom);
                end
            end
            sel_v[d] = 2'($urandom_range(0, 3));
            ordy[d]  = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 4'b0000; sel_v[d] = 2'b00; ordy[d] = 1'b0; acc[d] = 4'b0000;
            for (int c = 0; c < 4; c++) id[d][c] = 8'h00;
        end
        apply();
        @(posedge clk);
        #1;
        do_reset();

        // Round-robin with every channel valid
        iv[0] = 4'hF; ordy[0] = 1'b1;
        for (int c = 0; c < 4; c++) id[0][c] = 8'(8'h10 + c);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("rr_seq", 32'(get_oc(0)), 32'(k % 4));
            chk("rr_full_rate", 32'(get_ov(0)), 32'd1);
        end

        // Backpressure holds the beat on chan 3, then the next beat loads on release
        ordy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_rdy", 32'(get_rdy(0)), 32'd0);
            chk("bp_chan", 32'(get_oc(0)), 32'd3);
            chk("bp_data", 32'(get_od(0)), 32'h13);
        end
        ordy[0] = 1'b1;
        step();
        chk("bp_release", 32'(get_oc(0)), 32'd0);

        // Sparse traffic: ch2 alone, then ch0/ch3 compete with ptr at 3
        iv[0] = 4'b0000;
        step();
        iv[0] = 4'b0100; id[0][2] = 8'hA5;
        step();
        chk("sparse_data", 32'(get_od(0)), 32'hA5);
        chk("sparse_chan", 32'(get_oc(0)), 32'd2);
        iv[0] = 4'b1001;
        step();
        chk("sparse_next", 32'(get_oc(0)), 32'd3);
        iv[0] = 4'b0000;
        step();

        // Fixed select
        iv[1] = 4'b1101; ordy[1] = 1'b1; sel_v[1] = 2'd0;
        for (int c = 0; c < 4; c++) id[1][c] = 8'(8'h20 + c);
        step();
        chk("sel0_chan", 32'(get_oc(1)), 32'd0);
        sel_v[1] = 2'd1;
        step();
        chk("sel1_nogrant", 32'(get_ov(1)), 32'd0);
        sel_v[1] = 2'd3;
        step();
        chk("sel3_chan", 32'(get_oc(1)), 32'd3);
        chk("sel3_data", 32'(get_od(1)), 32'h23);
        iv[1] = 4'b0000;
        step();

        // Three channels wrap 2 -> 0
        iv[2] = 4'b0111; ordy[2] = 1'b1;
        for (int c = 0; c < 3; c++) id[2][c] = 8'(8'h30 + c);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("n3_seq", 32'(get_oc(2)), 32'(k % 3));
        end

        for (int k = 0; k < 400; k++) begin
            rand_inputs();
            step();
        end

        // Reset with a beat held, then arbitration restarts at ch0
        iv[0] = 4'hF; ordy[0] = 1'b0;
        step();
        chk("pre_rst_valid", 32'(get_ov(0)), 32'd1);
        do_reset();
        iv[0] = 4'hF; ordy[0] = 1'b1;
        for (int c = 0; c < 4; c++) id[0][c] = 8'(8'h40 + c);
        step();
        chk("post_rst_chan", 32'(get_oc(0)), 32'd0);

        for (int d = 0; d < 3; d++) begin
            iv[d] = 4'b0000; ordy[d] = 1'b1;
        end
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
